nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built from one 4-bit carry-look-ahead nibble stage.
//  Captures an operand pair through a valid/ready handshake.
//  Feeds the 4-bit CLA one nibble per clock, LSB nibble first, through a registered carry.
//  Assembles the sum and presents it on a valid/ready output.
//  Sits in front of, and wraps, the 4-bit CLA, extending it to wide datapaths with constant area.
// PARAMETERS
//  WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIB     derived localparam = WIDTH/4, number of RUN cycles
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair {a_in,b_in,cin_in} is valid
//  in_ready   out  1      block can accept an operand pair (high only in IDLE)
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B
//  cin_in     in   1      carry into the least-significant nibble
//  out_valid  out  1      sum_out/cout_out/ovf_out hold a completed result
//  out_ready  in   1      consumer takes the result
//  sum_out    out  WIDTH  A + B + cin, modulo 2^WIDTH
//  cout_out   out  1      carry out of bit WIDTH-1
//  ovf_out    out  1      two's-complement overflow: a[W-1]==b[W-1] && sum[W-1]!=a[W-1]
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0, ovf_out=0.
//    Nibble counter and carry register are 0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//    - in_valid && in_ready -> load a_in/b_in into shift registers, cin_in into the carry register.
//    - Clear the nibble counter; go to RUN.
//    - Later changes on the input pins are ignored.
//  RUN, each cycle:
//    - Add the low nibbles of A and B with the carry register.
//    - Shift the 4-bit sum into the result register from the top; store the nibble carry-out.
//    - Shift A and B right by 4; increment the counter.
//    - On the NIB-th cycle, register cout_out and ovf_out, then go to DONE.
//  Latency: out_valid rises exactly NIB clocks after the accepting edge (NIB=4 for WIDTH=16).
//  DONE:
//    - out_valid=1; sum_out, cout_out and ovf_out are held stable while out_ready=0.
//    - out_valid && out_ready -> go to IDLE; out_valid=0 next cycle.
//    - sum_out keeps its last value and is only meaningful while out_valid=1.
//  Throughput: one result per NIB+2 cycles. No new accept in RUN or DONE (in_ready=0).
//    in_valid is ignored there and stays pending for the producer.
//  out_ready while out_valid=0: no effect.
//  rst mid-operation (RUN or DONE): next cycle is IDLE with all reset values.
//    The partial result is discarded; rst has priority over any handshake in the same cycle.
//  Arithmetic: unsigned modulo 2^WIDTH; cout_out is bit WIDTH of the full sum.
//    ovf_out is derived from the captured MSBs of A and B plus the final sum MSB.
//  WIDTH=4 degenerate case: single RUN cycle; the same rules apply.
// STRUCTURE
//  Shared header nsa_defs.vh holds:
//    - NIBBLE_W=4
//    - FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//  Exactly one sub-module: carry_look_ahead_adder (4-bit a,b,cin -> sum,carry), instantiated once.
//    It is combinational.
//  All registers, the FSM and the handshake live in nibble_serial_adder.
// TESTING (WIDTH=16 unless stated)
//  1. a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0, ovf=0.
//     out_valid exactly 4 clks after accept.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
//     Carry ripples through all 4 nibble cycles.
//  3. a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
//     Also a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 clks in DONE -> outputs stable, in_ready=0.
//     A second in_valid pair is not accepted until 1 clk after out_ready=1.
//  5. Assert rst on the 2nd RUN cycle -> next clk IDLE, out_valid=0, sum_out=0, in_ready=1.
//     Then a=0, b=0, cin=1 -> sum=16'h0001.
//  6. WIDTH=4: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1, ovf=0; out_valid 1 clk after accept.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM encodings.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-look-ahead adder, purely combinational.
// All internal carries are computed directly from generate/propagate terms.
module carry_look_ahead_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pg
            assign w_p[gi] = i_a[gi] ^ i_b[gi];
            assign w_g[gi] = i_a[gi] & i_b[gi];
        end
    endgenerate

    // Flattened look-ahead carry equations
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sum
            assign o_sum[gi] = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    assign o_carry = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit CLA stage,
// processing one nibble per clock (LSB first) with a registered carry.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = $clog2(NIB + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_a_msb;
    logic             r_b_msb;

    logic [3:0]       w_nib_sum;
    logic             w_nib_carry;
    logic [WIDTH-1:0] w_sum_shift;
    logic             w_last;

    carry_look_ahead_adder u_cla (
        .i_a     (r_a[NIBBLE_W-1:0]),
        .i_b     (r_b[NIBBLE_W-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_nib_sum),
        .o_carry (w_nib_carry)
    );

    // New nibble enters the result register from the top, so after NIB shifts
    // the first (least-significant) nibble has arrived at bit 0.
    generate
        if (NIB == 1) begin : g_shift_single
            assign w_sum_shift = w_nib_sum;
        end else begin : g_shift_multi
            assign w_sum_shift = {w_nib_sum, r_sum[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    assign w_last = (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, NIB cycles of RUN, hold in DONE until taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)             w_state_next = S_RUN;
            S_RUN:   if (w_last)               w_state_next = S_DONE;
            S_DONE:  if (out_ready)            w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, nibble shifting, carry and flag registration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin_in;
                        r_cnt   <= '0;
                        r_a_msb <= a_in[WIDTH-1];
                        r_b_msb <= b_in[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_shift;
                    r_carry <= w_nib_carry;
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_nib_carry;
                        r_ovf  <= (r_a_msb == r_b_msb) && (w_nib_sum[3] != r_a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    assign sum_out  = r_sum;
    assign cout_out = r_cout;
    assign ovf_out  = r_ovf;

endmodule
